// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch/controller definitions: next-PC select codes, fetch FSM states, reset vector.
package instr_fetch_unit_pkg;

   localparam logic [2:0] NPC_PLUS4 = 3'b000;
   localparam logic [2:0] NPC_BEQ   = 3'b001;
   localparam logic [2:0] NPC_BNE   = 3'b010;
   localparam logic [2:0] NPC_J     = 3'b011;
   localparam logic [2:0] NPC_JAL   = 3'b100;
   localparam logic [2:0] NPC_JR    = 3'b101;

   localparam logic [1:0] ST_REQ  = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

   // Branch displacement: sign-extended word offset converted to bytes.
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory req/ack fetch channel between the fetch unit and instruction memory.
interface instr_fetch_unit_if #(
   parameter int ADDR_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [31:0]       imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/instr_fetch_unit_npc_calc.sv
// Combinational next-PC selection for the fetch unit, with a misaligned-target flag.
module npc_calc
   import instr_fetch_unit_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [25:0]       instr_idx,
   input  logic [2:0]        npc_sel,
   input  logic              zero,
   input  logic [31:0]       rs_data,
   output logic [ADDR_W-1:0] npc,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic              misaligned
);

   always_comb begin
      pc_plus4 = pc + ADDR_W'(4);
      npc      = pc_plus4;
      case (npc_sel)
         NPC_BEQ: if (zero)  npc = pc_plus4 + ADDR_W'(branch_offset(instr_idx[15:0]));
         NPC_BNE: if (!zero) npc = pc_plus4 + ADDR_W'(branch_offset(instr_idx[15:0]));
         NPC_J,
         NPC_JAL: npc = {pc_plus4[ADDR_W-1:28], instr_idx, 2'b00};
         NPC_JR:  npc = ADDR_W'(rs_data);
         default: npc = pc_plus4;
      endcase
      // Only a register target can be unaligned; the other sources derive from an aligned pc.
      misaligned = (npc[1:0] != 2'b00);
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one instruction in flight, req/ack fetch, PC commit on EXEC exit.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic               clk,
   input  logic               reset,
   instr_fetch_unit_if.master imem,
   output logic [31:0]        instr,
   output logic [5:0]         opcode,
   output logic [5:0]         funct,
   output logic               instr_valid,
   input  logic [2:0]         nPC_sel,
   input  logic               zero,
   input  logic [31:0]        rs_data,
   input  logic               stall,
   output logic [ADDR_W-1:0]  pc,
   output logic [ADDR_W-1:0]  pc_plus4,
   output logic               fault
);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       instr_q, instr_d;
   logic [ADDR_W-1:0] npc;
   logic              npc_misaligned;

   npc_calc #(.ADDR_W(ADDR_W)) u_npc_calc (
      .pc         (pc_q),
      .instr_idx  (instr_q[25:0]),
      .npc_sel    (nPC_sel),
      .zero       (zero),
      .rs_data    (rs_data),
      .npc        (npc),
      .pc_plus4   (pc_plus4),
      .misaligned (npc_misaligned)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      case (state_q)
         ST_REQ: begin
            if (imem.imem_ack) begin
               instr_d = imem.imem_rdata;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (!stall) begin
               if (npc_misaligned) begin
                  state_d = ST_HALT;
               end else begin
                  pc_d    = npc;
                  state_d = ST_REQ;
               end
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_REQ;
         pc_q    <= RESET_PC;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign imem.imem_req  = (state_q == ST_REQ);
   assign imem.imem_addr = pc_q;
   assign instr          = instr_q;
   assign opcode         = instr_q[31:26];
   assign funct          = instr_q[5:0];
   assign instr_valid    = (state_q == ST_EXEC);
   assign fault          = (state_q == ST_HALT);
   assign pc             = pc_q;

endmodule
